program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/loader_defs.sv | 21 ++
 rtl/program_loader.sv | 199 +++++++++++++++++++
 tb/tb_program_loader.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/loader_defs.sv
// Shared definitions for program_loader: data width and FSM state encodings.
// Build option: LOADER_CHECKSUM_EN adds the CHECK state, which verifies a
// trailing checksum byte after the last data byte.
package loader_defs;

    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT    = 3'd1,
        ST_ADDR    = 3'd2,
        ST_DATA    = 3'd3,
`ifdef LOADER_CHECKSUM_EN
        ST_CHECK   = 3'd4,
`endif
        ST_RELEASE = 3'd5,
        ST_DONE    = 3'd6,
        ST_ERROR   = 3'd7
    } state_e;

endpackage

// File: rtl/program_loader.sv
// program_loader: accepts a byte stream and replays it onto the computer's
// GLOBAL_BUS as MAR-load / RAM-write strobe pairs while holding the CPU in
// reset. Once the image is in RAM it pulses the microstep counter reset and
// releases the CPU.
// Build option: LOADER_CHECKSUM_EN expects one checksum byte (mod-256 sum of
// the data bytes) after the s_last byte; a mismatch ends in ERROR.
module program_loader
    import loader_defs::*;
#(
    parameter int RAM_ADDRESS_BITS = 8,
    parameter int RAM_SIZE         = 256
) (
    input  logic                      clk,
    input  logic                      RESET,
    input  logic                      start,
    input  logic [DATA_W-1:0]         s_data,
    input  logic                      s_valid,
    input  logic                      s_last,
    output logic                      s_ready,
    output logic [DATA_W-1:0]         bus_data,
    output logic                      mar_in,
    output logic                      ram_in,
    output logic                      RESET_counter,
    output logic                      cpu_RESETn,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic [RAM_ADDRESS_BITS:0] byte_count
);

    // Highest writable address; a non-last byte landing here overflows.
    localparam logic [RAM_ADDRESS_BITS-1:0] LAST_ADDR = RAM_ADDRESS_BITS'(RAM_SIZE - 1);

    state_e                      state_q, state_d;
    logic [RAM_ADDRESS_BITS-1:0] addr_q, addr_d;
    logic [RAM_ADDRESS_BITS:0]   count_q, count_d;
    logic [DATA_W-1:0]           data_q, data_d;
    logic                        last_q, last_d;
`ifdef LOADER_CHECKSUM_EN
    logic [DATA_W-1:0]           sum_q, sum_d;
    logic                        csum_phase_q, csum_phase_d;
`endif

    logic                        s_ready_q, s_ready_d;
    logic [DATA_W-1:0]           bus_data_q, bus_data_d;
    logic                        mar_in_q, mar_in_d;
    logic                        ram_in_q, ram_in_d;
    logic                        rst_cnt_q, rst_cnt_d;
    logic                        cpu_rstn_q, cpu_rstn_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
    logic                        error_q, error_d;

    // Next-state, datapath and output decode; outputs follow the next state so they register with it.
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path leaves it unassigned and infers a latch.
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        data_d  = data_q;
        last_d  = last_q;
`ifdef LOADER_CHECKSUM_EN
        sum_d        = sum_q;
        csum_phase_d = csum_phase_q;
`endif

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_d = ST_WAIT;
                    addr_d  = '0;
                    count_d = '0;
`ifdef LOADER_CHECKSUM_EN
                    sum_d        = '0;
                    csum_phase_d = 1'b0;
`endif
                end
            end
            ST_WAIT: begin
                if (s_valid && s_ready_q) begin
                    data_d  = s_data;
                    last_d  = s_last;
                    state_d = ST_ADDR;
`ifdef LOADER_CHECKSUM_EN
                    // The byte after the s_last byte is the checksum: compare, never write.
                    if (csum_phase_q) begin
                        state_d = ST_CHECK;
                    end
`endif
                end
            end
            ST_ADDR: begin
                state_d = ST_DATA;
            end
            ST_DATA: begin
                addr_d  = addr_q + RAM_ADDRESS_BITS'(1);
                count_d = count_q + (RAM_ADDRESS_BITS + 1)'(1);
`ifdef LOADER_CHECKSUM_EN
                sum_d = sum_q + data_q;
`endif
                if (last_q) begin
`ifdef LOADER_CHECKSUM_EN
                    csum_phase_d = 1'b1;
                    state_d      = ST_WAIT;
`else
                    state_d = ST_RELEASE;
`endif
                end else if (addr_q == LAST_ADDR) begin
                    state_d = ST_ERROR;
                end else begin
                    state_d = ST_WAIT;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CHECK: begin
                state_d = (data_q == sum_q) ? ST_RELEASE : ST_ERROR;
            end
`endif
            ST_RELEASE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        s_ready_d  = (state_d == ST_WAIT);
        mar_in_d   = (state_d == ST_ADDR);
        ram_in_d   = (state_d == ST_DATA);
        rst_cnt_d  = (state_d == ST_RELEASE);
        cpu_rstn_d = (state_d == ST_DONE);
        done_d     = (state_d == ST_DONE);
        error_d    = (state_d == ST_ERROR);
        busy_d     = !(state_d inside {ST_IDLE, ST_DONE, ST_ERROR});

        bus_data_d = '0;
        if (state_d == ST_ADDR) begin
            bus_data_d = DATA_W'(addr_d);
        end else if (state_d == ST_DATA) begin
            bus_data_d = data_d;
        end
    end

    // State, datapath and registered outputs; RESET clears everything at once, even mid-load.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            count_q    <= '0;
            data_q     <= '0;
            last_q     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_q        <= '0;
            csum_phase_q <= 1'b0;
`endif
            s_ready_q  <= 1'b0;
            bus_data_q <= '0;
            mar_in_q   <= 1'b0;
            ram_in_q   <= 1'b0;
            rst_cnt_q  <= 1'b0;
            cpu_rstn_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values from before this edge.
            state_q    <= state_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            data_q     <= data_d;
            last_q     <= last_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q        <= sum_d;
            csum_phase_q <= csum_phase_d;
`endif
            s_ready_q  <= s_ready_d;
            bus_data_q <= bus_data_d;
            mar_in_q   <= mar_in_d;
            ram_in_q   <= ram_in_d;
            rst_cnt_q  <= rst_cnt_d;
            cpu_rstn_q <= cpu_rstn_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign s_ready       = s_ready_q;
    assign bus_data      = bus_data_q;
    assign mar_in        = mar_in_q;
    assign ram_in        = ram_in_q;
    assign RESET_counter = rst_cnt_q;
    assign cpu_RESETn    = cpu_rstn_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign byte_count    = count_q;

endmodule

// File: tb/tb_program_loader.sv
// Testbench for program_loader. Two instances: dut_a with default sizing and
// dut_b with a 4-byte RAM for the overflow case. Writes are checked against a
// scoreboard of {dut, address, data} entries pushed when a byte is accepted.
// LOADER_CHECKSUM_EN must match the RTL build; it enables the checksum cases.
`timescale 1ns/1ps
module tb_program_loader;

    logic       clk = 1'b0;
    logic       RESET;
    logic       start_a, start_b;
    logic [7:0] s_data;
    logic       s_valid, s_last;

    logic       a_s_ready, a_mar_in, a_ram_in, a_rc, a_cpu_rstn, a_busy, a_done, a_error;
    logic [7:0] a_bus;
    logic [8:0] a_count;
    logic       b_s_ready, b_mar_in, b_ram_in, b_rc, b_cpu_rstn, b_busy, b_done, b_error;
    logic [7:0] b_bus;
    logic [2:0] b_count;

    always #5 clk = ~clk;

    program_loader dut_a (
        .clk(clk), .RESET(RESET), .start(start_a),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(a_s_ready),
        .bus_data(a_bus), .mar_in(a_mar_in), .ram_in(a_ram_in),
        .RESET_counter(a_rc), .cpu_RESETn(a_cpu_rstn),
        .busy(a_busy), .done(a_done), .error(a_error), .byte_count(a_count)
    );

    program_loader #(.RAM_ADDRESS_BITS(2), .RAM_SIZE(4)) dut_b (
        .clk(clk), .RESET(RESET), .start(start_b),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(b_s_ready),
        .bus_data(b_bus), .mar_in(b_mar_in), .ram_in(b_ram_in),
        .RESET_counter(b_rc), .cpu_RESETn(b_cpu_rstn),
        .busy(b_busy), .done(b_done), .error(b_error), .byte_count(b_count)
    );

    typedef struct packed {
        logic       s_ready;
        logic       mar_in;
        logic       ram_in;
        logic       rc;
        logic       cpu_rstn;
        logic       busy;
        logic       done;
        logic       error;
        logic [7:0] bus;
        logic [8:0] count;
    } obs_t;

    obs_t obs [2];

    always_comb begin
        obs[0] = {a_s_ready, a_mar_in, a_ram_in, a_rc, a_cpu_rstn, a_busy, a_done, a_error, a_bus, a_count};
        obs[1] = {b_s_ready, b_mar_in, b_ram_in, b_rc, b_cpu_rstn, b_busy, b_done, b_error, b_bus, 6'd0, b_count};
    end

    typedef struct {
        int         dut;
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    typedef struct {
        int          n;
        logic [31:0] bytes;   // byte i in bits [8*i +: 8]
        bit          toggle;
        int          exp_count;
        bit          exp_err;
    } vec_t;

    wr_t        exp_q [$];
    int         errors = 0;
    int         checks = 0;
    int         wr_cnt [2];
    int         mar_cnt [2];
    int         rc_cycles [2];
    logic [7:0] mar_addr [2];
    wr_t        mon_e;

    int         wr_base [2];
    int         mar_base [2];
    int         rc_base [2];
    logic [7:0] exp_addr [2];
    bit         vphase;
    vec_t       vecs [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Cycle monitor: scoreboard writes and per-cycle output rules for both instances.
    initial begin
        for (int d = 0; d < 2; d++) begin
            wr_cnt[d] = 0; mar_cnt[d] = 0; rc_cycles[d] = 0; mar_addr[d] = '0;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (obs[d].mar_in) begin
                    mar_cnt[d]++;
                    mar_addr[d] = obs[d].bus;
                end
                if (obs[d].ram_in) begin
                    wr_cnt[d]++;
                    check("write_expected", 32'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        mon_e = exp_q.pop_front();
                        check("write_dut", d, mon_e.dut);
                        check("write_addr", mar_addr[d], mon_e.addr);
                        check("write_data", obs[d].bus, mon_e.data);
                    end
                end
                if (obs[d].rc) rc_cycles[d]++;
                check("strobe_overlap", obs[d].mar_in & obs[d].ram_in, 0);
                if (!obs[d].mar_in && !obs[d].ram_in) check("bus_idle_zero", obs[d].bus, 0);
                else check("ready_low_in_addr_data", obs[d].s_ready, 0);
                check("cpu_rstn_only_when_done", obs[d].cpu_rstn, obs[d].done);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic logic rdy(input int d);
        return (d == 0) ? obs[0].s_ready : obs[1].s_ready;
    endfunction

    task automatic start_load(input int d);
        exp_addr[d] = '0;
        wr_base[d]  = wr_cnt[d];
        mar_base[d] = mar_cnt[d];
        rc_base[d]  = rc_cycles[d];
        if (d == 0) start_a = 1'b1; else start_b = 1'b1;
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    // Offer one byte until accepted; optionally time accept-to-next-ready.
    task automatic send_byte(input int d, input logic [7:0] data, input logic last,
                             input bit toggle, input bit push, input bit meas);
        bit ok = 1'b0;
        int gap;
        s_data = data;
        s_last = last;
        for (int i = 0; i < 40 && !ok; i++) begin
            s_valid = toggle ? vphase : 1'b1;
            if (toggle) vphase = ~vphase;
            if (s_valid && rdy(d)) begin
                ok = 1'b1;
                if (push) begin
                    exp_q.push_back('{d, exp_addr[d], data});
                    exp_addr[d] = exp_addr[d] + 8'd1;
                end
            end
            tick();
        end
        s_valid = 1'b0;
        check("byte_accepted", ok, 1);
        if (meas) begin
            gap = 1;
            while (!rdy(d) && gap < 10) begin
                tick();
                gap++;
            end
            check("accept_to_ready_cycles", gap, 3);
        end
    endtask

    task automatic run_load(input int d, input int n, input logic [31:0] bytes,
                            input bit toggle, input bit meas, input logic [7:0] cs_delta);
        logic [7:0] sum = '0;
        start_load(d);
        for (int i = 0; i < n; i++) begin
            sum = sum + bytes[8*i +: 8];
            send_byte(d, bytes[8*i +: 8], i == n - 1, toggle, 1'b1, meas && (i != n - 1));
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(d, sum + cs_delta, 1'b0, toggle, 1'b0, 1'b0);
`else
        if (cs_delta != 8'd0) sum = sum + cs_delta;
`endif
    endtask

    // Bounded wait for the load to settle, then check final status and strobe counts.
    task automatic finish_checks(input int d, input int n, input int exp_count, input bit exp_err);
        bit fin = 1'b0;
        for (int i = 0; i < 20 && !fin; i++) begin
            if (obs[d].done || obs[d].error) fin = 1'b1;
            else tick();
        end
        check("load_completed", fin, 1);
        tick();
        check("done", obs[d].done, !exp_err);
        check("error", obs[d].error, exp_err);
        check("cpu_rstn", obs[d].cpu_rstn, !exp_err);
        check("busy_clear", obs[d].busy, 0);
        check("byte_count", obs[d].count, exp_count);
        check("ram_writes", wr_cnt[d] - wr_base[d], n);
        check("mar_pulses", mar_cnt[d] - mar_base[d], n);
        check("reset_counter_cycles", rc_cycles[d] - rc_base[d], exp_err ? 0 : 1);
        check("scoreboard_empty", exp_q.size(), 0);
    endtask

    initial begin
        bit seen;

        vecs[0] = '{3, 32'h00E02F1E, 1'b0, 3, 1'b0};
        vecs[1] = '{4, 32'h7EFF8001, 1'b1, 4, 1'b0};
        vecs[2] = '{1, 32'h000000A5, 1'b0, 1, 1'b0};
        vecs[3] = '{2, 32'h0000FF00, 1'b1, 2, 1'b0};

        RESET   = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        s_data  = '0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        vphase  = 1'b1;
        tick();
        tick();
        check("reset_state_a", obs[0], 0);
        check("reset_state_b", obs[1], 0);
        RESET = 1'b0;
        tick();
        check("idle_after_reset", obs[0], 0);

        // Table-driven loads on the full-size instance.
        for (int i = 0; i < 4; i++) begin
            run_load(0, vecs[i].n, vecs[i].bytes, vecs[i].toggle, 1'b1, 8'd0);
            finish_checks(0, vecs[i].n, vecs[i].exp_count, vecs[i].exp_err);
        end

        // start while busy is ignored; addresses continue.
        start_load(0);
        send_byte(0, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check("busy_after_start_in_addr", obs[0].busy, 1);
        tick();
        tick();
        check("ready_before_wait_start", rdy(0), 1);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        send_byte(0, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0);
        send_byte(0, 8'h33, 1'b1, 1'b0, 1'b1, 1'b0);
`ifdef LOADER_CHECKSUM_EN
        send_byte(0, 8'h66, 1'b0, 1'b0, 1'b0, 1'b0);
`endif
        finish_checks(0, 3, 3, 1'b0);

        // Overflow on the 4-byte instance: fourth byte still written, then ERROR.
        start_load(1);
        for (int i = 0; i < 4; i++) begin
            send_byte(1, 8'hC0 + 8'(i), 1'b0, 1'b0, 1'b1, 1'b0);
        end
        finish_checks(1, 4, 4, 1'b1);
        s_data  = 8'hC4;
        s_last  = 1'b1;
        s_valid = 1'b1;
        seen    = 1'b0;
        for (int i = 0; i < 6; i++) begin
            seen |= rdy(1);
            tick();
        end
        s_valid = 1'b0;
        check("no_accept_in_error", seen, 0);
        check("error_held", obs[1].error, 1);
        check("cpu_rstn_low_in_error", obs[1].cpu_rstn, 0);

        // RESET during DATA of byte 2, then a fresh load from address 0.
        start_load(0);
        send_byte(0, 8'h44, 1'b0, 1'b0, 1'b1, 1'b0);
        send_byte(0, 8'h55, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        check("in_data_before_reset", obs[0].ram_in, 1);
        RESET = 1'b1;
        #1;
        check("reset_mid_load_a", obs[0], 0);
        check("reset_clears_error_b", obs[1], 0);
        tick();
        RESET = 1'b0;
        tick();
        run_load(0, vecs[0].n, vecs[0].bytes, 1'b0, 1'b0, 8'd0);
        finish_checks(0, vecs[0].n, vecs[0].exp_count, 1'b0);

`ifdef LOADER_CHECKSUM_EN
        run_load(0, 2, 32'h00002010, 1'b0, 1'b0, 8'd0);
        finish_checks(0, 2, 2, 1'b0);
        run_load(0, 2, 32'h00002010, 1'b0, 1'b0, 8'd1);
        finish_checks(0, 2, 2, 1'b1);
`endif

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
